line_window_3x3: RTL and testbench

- Consumes the pixel stream together with the line-delayed taps produced by two cascaded RAM-based 640x16 shift registers (row-1 and row-2).
- Forms a sliding 3x3 pixel window, tracks the frame position, and flags valid windows only where all nine pixels lie inside the frame.
- Computes a pipelined 3x3 sum for the downstream box-filter / blob stage of the tracker.

---
 rtl/line_window_3x3.sv | 154 +++++++++++++++
 tb/tb_line_window_3x3.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_window_3x3.sv
// line_window_3x3: sliding 3x3 pixel window over a raster stream with
// line-delayed taps, frame position tracking and a pipelined 3x3 sum.
//
// Ports:
//   clk        system clock, rising edge
//   Reset      asynchronous active-high reset
//   de         data enable, row0/row1/row2 valid this cycle
//   sof        start of frame (qualified by de), pixel is col 0 / row 0
//   row0       current-line pixel
//   row1       pixel one line above (first line-delay tap)
//   row2       pixel two lines above (second line-delay tap)
//   win        window, [DSIZE*(3r+c) +: DSIZE] = row r (0 oldest), col c (0 oldest)
//   win_valid  win holds a window fully inside the frame (1-cycle strobe)
//   center_x   column of the window centre pixel
//   center_y   row of the window centre pixel
//   sum        sum of the nine window pixels (2 cycles after win)
//   sum_valid  win_valid delayed by two cycles
module line_window_3x3 #(
    parameter int DSIZE = 16,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int XSIZE = $clog2(IMG_W),
    parameter int YSIZE = $clog2(IMG_H)
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic                 de,
    input  logic                 sof,
    input  logic [DSIZE-1:0]     row0,
    input  logic [DSIZE-1:0]     row1,
    input  logic [DSIZE-1:0]     row2,
    output logic [9*DSIZE-1:0]   win,
    output logic                 win_valid,
    output logic [XSIZE-1:0]     center_x,
    output logic [YSIZE-1:0]     center_y,
    output logic [DSIZE+3:0]     sum,
    output logic                 sum_valid
);

    localparam logic [XSIZE-1:0] LAST_X = XSIZE'(IMG_W - 1);
    localparam logic [YSIZE-1:0] LAST_Y = YSIZE'(IMG_H - 1);
    localparam logic [XSIZE-1:0] MIN_X  = XSIZE'(2);
    localparam logic [YSIZE-1:0] MIN_Y  = YSIZE'(2);
    localparam logic [XSIZE-1:0] ONE_X  = XSIZE'(1);
    localparam logic [YSIZE-1:0] ONE_Y  = YSIZE'(1);

    // Window storage, r_w[row][col]; row 0 is the oldest line.
    logic [DSIZE-1:0] r_w [3][3];

    // Position of the next pixel to be accepted.
    logic [XSIZE-1:0] r_col;
    logic [YSIZE-1:0] r_row;

    // Position of the pixel presented this cycle and the one after it.
    logic [XSIZE-1:0] w_c;
    logic [YSIZE-1:0] w_r;
    logic [XSIZE-1:0] w_c_nxt;
    logic [YSIZE-1:0] w_r_nxt;
    logic             w_in_frame;

    // Sum pipeline: per-row partial sums, then the total.
    logic [DSIZE+1:0] r_rs [3];
    logic             r_sv1;

    // sof resyncs the counters onto the current pixel.
    always_comb begin
        w_c = sof ? '0 : r_col;
        w_r = sof ? '0 : r_row;
        if (w_c != LAST_X) begin
            w_c_nxt = w_c + ONE_X;
            w_r_nxt = w_r;
        end else begin
            w_c_nxt = '0;
            w_r_nxt = (w_r != LAST_Y) ? w_r + ONE_Y : '0;
        end
        // Columns 0/1 would pull pixels from the previous line.
        w_in_frame = (w_c >= MIN_X) && (w_r >= MIN_Y);
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_col <= '0;
            r_row <= '0;
        end else if (de) begin
            r_col <= w_c_nxt;
            r_row <= w_r_nxt;
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    r_w[r][c] <= '0;
                end
            end
        end else if (de) begin
            for (int r = 0; r < 3; r++) begin
                r_w[r][0] <= r_w[r][1];
                r_w[r][1] <= r_w[r][2];
            end
            r_w[0][2] <= row2;
            r_w[1][2] <= row1;
            r_w[2][2] <= row0;
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            win_valid <= 1'b0;
            center_x  <= '0;
            center_y  <= '0;
        end else if (de) begin
            win_valid <= w_in_frame;
            center_x  <= w_c - ONE_X;
            center_y  <= w_r - ONE_Y;
        end else begin
            win_valid <= 1'b0;
        end
    end

    always_comb begin
        win = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                win[DSIZE*(3*r+c) +: DSIZE] = r_w[r][c];
            end
        end
    end

    // Free-running: the valid bits travel alongside the data.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            for (int r = 0; r < 3; r++) begin
                r_rs[r] <= '0;
            end
            r_sv1     <= 1'b0;
            sum       <= '0;
            sum_valid <= 1'b0;
        end else begin
            for (int r = 0; r < 3; r++) begin
                r_rs[r] <= (DSIZE+2)'(r_w[r][0])
                         + (DSIZE+2)'(r_w[r][1])
                         + (DSIZE+2)'(r_w[r][2]);
            end
            r_sv1     <= win_valid;
            sum       <= (DSIZE+4)'(r_rs[0])
                       + (DSIZE+4)'(r_rs[1])
                       + (DSIZE+4)'(r_rs[2]);
            sum_valid <= r_sv1;
        end
    end

endmodule

// File: tb/tb_line_window_3x3.sv
// tb_line_window_3x3: randomized and directed stimulus for line_window_3x3
// (8x4 frame) checked against a queue-based window/position model.
module tb_line_window_3x3;

    localparam int W = 8;
    localparam int H = 4;
    localparam int D = 16;

    logic            clk = 1'b0;
    logic            Reset = 1'b0;
    logic            de = 1'b0;
    logic            sof = 1'b0;
    logic [D-1:0]    row0 = '0;
    logic [D-1:0]    row1 = '0;
    logic [D-1:0]    row2 = '0;
    logic [9*D-1:0]  win;
    logic            win_valid;
    logic [2:0]      center_x;
    logic [1:0]      center_y;
    logic [D+3:0]    sum;
    logic            sum_valid;

    always #5 clk = ~clk;

    line_window_3x3 #(
        .DSIZE (D),
        .IMG_W (W),
        .IMG_H (H)
    ) dut (
        .clk       (clk),
        .Reset     (Reset),
        .de        (de),
        .sof       (sof),
        .row0      (row0),
        .row1      (row1),
        .row2      (row2),
        .win       (win),
        .win_valid (win_valid),
        .center_x  (center_x),
        .center_y  (center_y),
        .sum       (sum),
        .sum_valid (sum_valid)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [159:0] got,
                       input logic [159:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Reference model: each queue holds one window row, oldest column first.
    int         mc, mr;
    logic [D-1:0] q0[$], q1[$], q2[$];
    bit         m_wv;
    int         m_cx, m_cy;
    int         m_s1, e_sum;
    bit         m_v1, e_sv;

    function automatic void m_reset();
        mc = 0; mr = 0;
        q0 = '{16'h0, 16'h0, 16'h0};
        q1 = '{16'h0, 16'h0, 16'h0};
        q2 = '{16'h0, 16'h0, 16'h0};
        m_wv = 0; m_cx = 0; m_cy = 0;
        m_s1 = 0; e_sum = 0; m_v1 = 0; e_sv = 0;
    endfunction

    function automatic int m_winsum();
        int s = 0;
        for (int i = 0; i < 3; i++)
            s += int'(q0[i]) + int'(q1[i]) + int'(q2[i]);
        return s;
    endfunction

    function automatic logic [9*D-1:0] m_win();
        logic [9*D-1:0] w = '0;
        for (int c = 0; c < 3; c++) begin
            w[D*c +: D]     = q0[c];
            w[D*(3+c) +: D] = q1[c];
            w[D*(6+c) +: D] = q2[c];
        end
        return w;
    endfunction

    function automatic void m_edge(bit d, bit s, logic [D-1:0] p0,
                                   logic [D-1:0] p1, logic [D-1:0] p2);
        int c, r;
        e_sum = m_s1;
        e_sv  = m_v1;
        m_s1  = m_winsum();
        m_v1  = m_wv;
        if (d) begin
            c = s ? 0 : mc;
            r = s ? 0 : mr;
            q0.push_back(p2); void'(q0.pop_front());
            q1.push_back(p1); void'(q1.pop_front());
            q2.push_back(p0); void'(q2.pop_front());
            m_wv = (c >= 2) && (r >= 2);
            m_cx = c - 1;
            m_cy = r - 1;
            if (c < W - 1) begin
                mc = c + 1; mr = r;
            end else begin
                mc = 0; mr = (r < H - 1) ? r + 1 : 0;
            end
        end else begin
            m_wv = 0;
        end
    endfunction

    task automatic check_all();
        chk("win", win, m_win());
        chk("win_valid", win_valid, m_wv);
        if (m_wv) begin
            chk("center_x", center_x, m_cx);
            chk("center_y", center_y, m_cy);
        end
        chk("sum", sum, e_sum);
        chk("sum_valid", sum_valid, e_sv);
    endtask

    task automatic step(input bit d, input bit s, input logic [D-1:0] p0,
                        input logic [D-1:0] p1, input logic [D-1:0] p2);
        de = d; sof = s; row0 = p0; row1 = p1; row2 = p2;
        @(posedge clk);
        #1;
        m_edge(d, s, p0, p1, p2);
        check_all();
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        #1;
        chk("rst_win", win, 0);
        chk("rst_win_valid", win_valid, 0);
        chk("rst_center_x", center_x, 0);
        chk("rst_center_y", center_y, 0);
        chk("rst_sum", sum, 0);
        chk("rst_sum_valid", sum_valid, 0);
        m_reset();
        for (int i = 0; i < 2; i++) begin
            de = ~de;
            row0 = 16'($urandom);
            @(posedge clk);
            #1;
            chk("rst_hold_win", win, 0);
            chk("rst_hold_wv", win_valid, 0);
            chk("rst_hold_sum", sum, 0);
            chk("rst_hold_sv", sum_valid, 0);
        end
        Reset = 1'b0;
        de = 1'b0;
        sof = 1'b0;
    endtask

    logic [D+3:0] rq[$], sa[$], sb[$];

    task automatic ramp(input bit gap);
        int p = 0;
        int gaps = 0;
        int fp;
        int pcx1 = 0, pcy1 = 0, pcx2 = 0, pcy2 = 0;
        rq.delete();
        while (p < 48) begin
            if (gap && p == 20 && gaps < 3) begin
                step(0, 0, 16'($urandom), 16'($urandom), 16'($urandom));
                gaps++;
            end else begin
                fp = p % (W * H);
                step(1, p == 0, 16'(fp), 16'(fp - W), 16'(fp - 2 * W));
                p++;
            end
            if (e_sv) begin
                rq.push_back(sum);
                chk("ramp_sum", sum, 9 * (W * pcy2 + pcx2));
            end
            pcx2 = pcx1; pcy2 = pcy1;
            pcx1 = m_cx; pcy1 = m_cy;
        end
    endtask

    initial begin
        int first, fcx, fcy, fs, n, k;
        #2;
        do_reset();
        for (int i = 0; i < 3; i++)
            step(0, 0, 16'($urandom), 16'($urandom), 16'($urandom));

        // constant-one frame
        first = 0; fcx = 0; fcy = 0; fs = 0;
        for (int i = 1; i <= 40; i++) begin
            step(1, i == 1, 16'h1, 16'h1, 16'h1);
            if (first != 0 && i == first + 2) fs = int'(sum);
            if (win_valid && first == 0) begin
                first = i; fcx = center_x; fcy = center_y;
            end
        end
        chk("ones_first_valid", first, 19);
        chk("ones_center_x", fcx, 1);
        chk("ones_center_y", fcy, 1);
        chk("ones_sum", fs, 9);

        // ramp, gapless then with a 3-cycle gap at (4,2)
        do_reset();
        ramp(0);
        sa = rq;
        chk("ramp_first_sum", (sa.size() > 0) ? sa[0] : 20'd0, 81);
        do_reset();
        ramp(1);
        sb = rq;
        chk("gap_len", sb.size(), sa.size());
        for (int i = 0; i < sa.size() && i < sb.size(); i++)
            chk("gap_seq", sb[i], sa[i]);

        // sof resync at (5,2)
        do_reset();
        k = 0;
        while (!(mc == 5 && mr == 2) && k < 100) begin
            step(1, 0, 16'($urandom), 16'($urandom), 16'($urandom));
            k++;
        end
        step(1, 1, 16'($urandom), 16'($urandom), 16'($urandom));
        n = 1;
        while (!win_valid && n < 40) begin
            step(1, 0, 16'($urandom), 16'($urandom), 16'($urandom));
            n++;
        end
        chk("sof_resync_idx", n, 19);
        chk("sof_center_x", center_x, 1);
        chk("sof_center_y", center_y, 1);

        // reset while a sum is in flight
        do_reset();
        for (int i = 0; i < 19; i++)
            step(1, 0, 16'h5, 16'h5, 16'h5);
        chk("pend_win_valid", win_valid, 1);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 16'h0, 16'h0, 16'h0);
            chk("rst_drop", sum_valid, 0);
        end

        // random traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 999) < 3)
                do_reset();
            else
                step($urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0,
                     16'($urandom), 16'($urandom), 16'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
